// File: rtl/sc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sc_ctrl_pkg
// Shared constants for the interval controller and its counter core.
//   SC_WIDTH_DEF : default counter / limit width in bits
//   S_IDLE/S_RUN : controller state encoding (one bit, two states)
// ---------------------------------------------------------------------------
package sc_ctrl_pkg;

    localparam int   SC_WIDTH_DEF = 4;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

endpackage

// File: rtl/sc_count_core.sv
// ---------------------------------------------------------------------------
// sc_count_core
// WIDTH-bit synchronous up-counter with synchronous clear.
// Ports:
//   clk   in   rising-edge clock
//   reset in   synchronous active-high reset (count -> 0)
//   clr   in   synchronous clear, takes priority over en
//   en    in   increment by one at the clock edge
//   q     out  current count
// ---------------------------------------------------------------------------
module sc_count_core
    import sc_ctrl_pkg::*;
#(
    parameter int WIDTH = SC_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sc_interval_ctrl.sv
// ---------------------------------------------------------------------------
// sc_interval_ctrl
// Interval sequencer around sc_count_core. Times one-shot intervals (done
// pulse) or periodic intervals (tick train) of limit+1 cycles.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   start     in   begin interval (honoured in IDLE only)
//   stop      in   abort interval (honoured in RUN only; dominates start)
//   periodic  in   auto-restart select, captured on accepted start
//   limit     in   terminal count, captured on accepted start
//   pause     in   (only when SC_CTRL_PAUSE_EN is defined) hold the count
//   busy      out  high while in RUN
//   tick      out  one-cycle pulse when count reaches the captured limit
//   done      out  tick of a one-shot interval
//   count     out  current counter value
// Build option: define SC_CTRL_PAUSE_EN to add the pause input; otherwise
// the controller behaves as if pause were tied low.
// ---------------------------------------------------------------------------
module sc_interval_ctrl
    import sc_ctrl_pkg::*;
#(
    parameter int WIDTH = SC_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [WIDTH-1:0] limit,
`ifdef SC_CTRL_PAUSE_EN
    input  logic             pause,
`endif
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    logic             r_state;
    logic             w_state_next;
    logic [WIDTH-1:0] r_limit;
    logic             r_periodic;
    logic             w_pause;
    logic             w_accept;
    logic             w_hit;
    logic             w_clr;
    logic             w_en;
    logic [WIDTH-1:0] w_count;

`ifdef SC_CTRL_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // Start is accepted only from IDLE and only when stop is not also asserted.
    assign w_accept = (r_state == S_IDLE) && start && !stop;

    // Terminal count reached in a cycle that is not aborted or frozen.
    assign w_hit = (r_state == S_RUN) && (w_count == r_limit) && !stop && !w_pause;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Interval configuration is frozen for the whole run.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_limit    <= '0;
            r_periodic <= 1'b0;
        end else if (w_accept) begin
            r_limit    <= limit;
            r_periodic <= periodic;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                if (stop) begin
                    w_state_next = S_IDLE;
                end else if (w_hit && !r_periodic) begin
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    // Output / counter-control logic. The counter is held cleared in IDLE,
    // so the first RUN cycle always shows 0; clearing at the terminal count
    // means an all-ones limit never wraps through 0 unseen.
    always_comb begin
        busy = 1'b0;
        tick = 1'b0;
        done = 1'b0;
        w_clr = 1'b1;
        w_en  = 1'b0;
        if (r_state == S_RUN) begin
            busy  = 1'b1;
            tick  = w_hit;
            done  = w_hit && !r_periodic;
            w_clr = stop || w_hit;
            w_en  = !w_pause;
        end
    end

    sc_count_core #(
        .WIDTH (WIDTH)
    ) u_count_core (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .en    (w_en),
        .q     (w_count)
    );

    assign count = w_count;

endmodule

// File: tb/tb_sc_interval_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sc_interval_ctrl
// Cycle-level reference model feeds a scoreboard queue of expected outputs;
// directed latency / tick-count checks cover the interval boundaries.
// ---------------------------------------------------------------------------
module tb_sc_interval_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, start, stop, periodic, pause;
    logic [W-1:0] limit;
    logic         busy, tick, done;
    logic [W-1:0] count;

    always #5 clk = ~clk;

    sc_interval_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .limit    (limit),
`ifdef SC_CTRL_PAUSE_EN
        .pause    (pause),
`endif
        .busy     (busy),
        .tick     (tick),
        .done     (done),
        .count    (count)
    );

    typedef struct packed {
        logic         busy;
        logic         tick;
        logic         done;
        logic [W-1:0] count;
    } exp_t;

    exp_t exp_q[$];

    int n_vec   = 0;
    int n_err   = 0;
    int cyc_no  = 0;
    int t_cyc   = -1;
    int n_ticks = 0;
    int n_dones = 0;
    int s_cyc   = 0;

    // reference model state
    logic         m_known = 1'b0;
    logic         m_run;
    logic [W-1:0] m_cnt;
    logic [W-1:0] m_lim;
    logic         m_per;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_no, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, push expected outputs, compare mid-cycle,
    // then advance the model to the state after the next edge.
    task automatic cyc(input logic rs, input logic st, input logic sp, input logic pz,
                       input logic per, input logic [W-1:0] lim);
        exp_t e;
        logic m_tick;
        @(posedge clk);
        #1;
        cyc_no++;
        reset = rs; start = st; stop = sp; pause = pz; periodic = per; limit = lim;
        m_tick   = m_run && (m_cnt == m_lim) && !sp && !pz;
        e.busy   = m_run;
        e.tick   = m_tick;
        e.done   = m_tick && !m_per;
        e.count  = m_cnt;
        if (m_known) exp_q.push_back(e);
        @(negedge clk);
        if (tick === 1'b1) begin
            n_ticks++;
            if (t_cyc < 0) t_cyc = cyc_no;
        end
        if (done === 1'b1) n_dones++;
        if (m_known) begin
            e = exp_q.pop_front();
            chk("busy",  32'(busy),  32'(e.busy));
            chk("tick",  32'(tick),  32'(e.tick));
            chk("done",  32'(done),  32'(e.done));
            chk("count", 32'(count), 32'(e.count));
            $display("cyc %0d rs=%b st=%b sp=%b pz=%b -> busy=%b tick=%b done=%b count=%0d",
                     cyc_no, rs, st, sp, pz, busy, tick, done, count);
        end
        if (rs) begin
            m_known = 1'b1; m_run = 1'b0; m_cnt = '0; m_lim = '0; m_per = 1'b0;
        end else if (!m_run) begin
            m_cnt = '0;
            if (st && !sp) begin
                m_run = 1'b1; m_lim = lim; m_per = per;
            end
        end else if (sp) begin
            m_run = 1'b0; m_cnt = '0;
        end else if (m_tick) begin
            m_cnt = '0; m_run = m_per;
        end else if (!pz) begin
            m_cnt = m_cnt + 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Starts an interval and clears the tick bookkeeping.
    task automatic go(input logic per, input logic [W-1:0] lim);
        t_cyc = -1; n_ticks = 0; n_dones = 0;
        s_cyc = cyc_no + 1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, per, lim);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; periodic = 1'b0; limit = '0;

        // 1: reset held with start asserted
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        idle(2);

        // start and stop together in IDLE: stop dominates
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
        idle(1);

        // 2: one-shot L=5
        go(1'b0, 4'd5);
        idle(8);
        chk("os5_lat",   32'(t_cyc - s_cyc), 32'd6);
        chk("os5_dones", 32'(n_dones), 32'd1);

        // 3: periodic L=3, twelve RUN cycles then stop
        go(1'b1, 4'd3);
        idle(12);
        chk("per3_ticks", 32'(n_ticks), 32'd3);
        chk("per3_dones", 32'(n_dones), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(2);

        // 4: L=9 one-shot, start pulses and limit change mid-run, stop at count 2
        go(1'b0, 4'd9);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(12);
        chk("stop_ticks", 32'(n_ticks), 32'd0);

        // 5: L=0 and L=15 boundaries
        go(1'b0, 4'd0);
        idle(3);
        chk("l0_lat",   32'(t_cyc - s_cyc), 32'd1);
        go(1'b1, 4'd0);
        idle(4);
        chk("l0p_ticks", 32'(n_ticks), 32'd4);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        go(1'b0, 4'd15);
        idle(20);
        chk("l15_lat",   32'(t_cyc - s_cyc), 32'd16);
        chk("l15_ticks", 32'(n_ticks), 32'd1);

        // 6: reset mid-run at count 6
        go(1'b0, 4'd9);
        idle(6);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle(3);
        chk("rst_ticks", 32'(n_ticks), 32'd0);

`ifdef SC_CTRL_PAUSE_EN
        // pause for three cycles at count 2 with L=4
        go(1'b0, 4'd4);
        idle(2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(6);
        chk("pause_lat", 32'(t_cyc - s_cyc), 32'd8);
`endif

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
